// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and constants for the sequential restoring divider
//
// Contents:
//   DEF_WIDTH  - default operand/quotient/remainder width
//   state_e    - controller state encoding (ST_FIX used only with SEQ_DIVIDER_SIGNED_DIV_EN)
//   cnt_width  - iteration counter width for a given operand width
package seq_div_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_ITER   = 3'd2,
        ST_FIX    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_div_datapath.sv
// rtl/seq_div_datapath.sv - A/Q/M registers, trial subtractor, counter and result registers
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_DIV_EN (magnitude capture + sign fix-up)
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   data_in           - shared operand bus (divisor on ld_m, dividend on ld_q)
//   ld_m              - capture divisor
//   ld_q              - capture dividend, clear A, preset counter, handle divide by zero
//   iter              - perform one restoring iteration
//   fix               - (signed build only) apply sign correction when latching
//   latch_out         - update quotient/remainder/div_by_zero result registers
//   cnt_one           - counter equals 1 (last iteration this cycle)
//   m_zero            - captured divisor is zero
//   div_by_zero, quotient, remainder - registered results
module seq_div_datapath
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_m,
    input  logic             ld_q,
    input  logic             iter,
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    input  logic             fix,
`endif
    input  logic             latch_out,
    output logic             cnt_one,
    output logic             m_zero,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = cnt_width(WIDTH);

    // The partial remainder never reaches the divisor after a restoring step,
    // so its top bit is always zero; only the low WIDTH bits are stored and
    // the extra bit appears only in the trial subtraction.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   s_hi;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] a_iter;
    logic [WIDTH-1:0] q_iter;
    logic [WIDTH-1:0] in_mag;

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    logic m_neg_q, m_neg_d;
    logic n_neg_q, n_neg_d;
`endif

    always_comb begin
        s_hi   = {a_q, q_q[WIDTH-1]};
        trial  = s_hi - {1'b0, m_q};
        fits   = ~trial[WIDTH];
        a_iter = fits ? trial[WIDTH-1:0] : s_hi[WIDTH-1:0];
        q_iter = {q_q[WIDTH-2:0], fits};
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
        in_mag = data_in[WIDTH-1] ? (~data_in + 1'b1) : data_in;
`else
        in_mag = data_in;
`endif
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
        m_neg_d = m_neg_q;
        n_neg_d = n_neg_q;
`endif

        if (ld_m) begin
            m_d = in_mag;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            m_neg_d = data_in[WIDTH-1];
`endif
        end

        if (ld_q) begin
            q_d   = in_mag;
            a_d   = '0;
            cnt_d = CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            n_neg_d = data_in[WIDTH-1];
`endif
            // Divide by zero: remainder reports the dividend exactly as given.
            if (m_zero) begin
                quot_d = '1;
                rem_d  = data_in;
                dz_d   = 1'b1;
            end
        end

        if (iter) begin
            a_d   = a_iter;
            q_d   = q_iter;
            cnt_d = cnt_q - CW'(1);
        end

        if (latch_out) begin
            dz_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            if (fix) begin
                // Truncation toward zero: quotient sign is the XOR of operand
                // signs, remainder follows the dividend. min_int/-1 falls out
                // naturally as magnitude 0x80..0 with no negation.
                quot_d = (m_neg_q ^ n_neg_q) ? (~q_q + 1'b1) : q_q;
                rem_d  = n_neg_q ? (~a_q + 1'b1) : a_q;
            end else begin
                quot_d = q_iter;
                rem_d  = a_iter;
            end
`else
            quot_d = q_iter;
            rem_d  = a_iter;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            m_neg_q <= 1'b0;
            n_neg_q <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            m_neg_q <= m_neg_d;
            n_neg_q <= n_neg_d;
`endif
        end
    end

    assign cnt_one     = (cnt_q == CW'(1));
    assign m_zero      = (m_q == '0);
    assign div_by_zero = dz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider: FSM controller around seq_div_datapath
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_DIV_EN (two's complement operands, extra FIX cycle)
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin an operation (sampled in IDLE or DONE)
//   data_in      - divisor in the start cycle, dividend in the following cycle
//   busy         - operation in progress (LOAD_D, ITER, FIX)
//   done         - result valid (DONE state)
//   div_by_zero  - divisor was zero, valid with done
//   quotient     - registered quotient, valid with done
//   remainder    - registered remainder, valid with done
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    state_e state_q, state_d;

    logic ld_m, ld_q, iter, latch_out;
    logic cnt_one, m_zero;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    logic fix;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_m      = 1'b0;
        ld_q      = 1'b0;
        iter      = 1'b0;
        latch_out = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
        fix       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ld_m    = 1'b1;
                    state_d = ST_LOAD_D;
                end
            end
            ST_LOAD_D: begin
                busy    = 1'b1;
                ld_q    = 1'b1;
                state_d = m_zero ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                busy = 1'b1;
                iter = 1'b1;
                if (cnt_one) begin
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
                    state_d = ST_FIX;
`else
                    latch_out = 1'b1;
                    state_d   = ST_DONE;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            ST_FIX: begin
                busy      = 1'b1;
                fix       = 1'b1;
                latch_out = 1'b1;
                state_d   = ST_DONE;
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                // Back-to-back: a new divisor can be taken in the first DONE cycle.
                if (start) begin
                    ld_m    = 1'b1;
                    state_d = ST_LOAD_D;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    seq_div_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .ld_m        (ld_m),
        .ld_q        (ld_q),
        .iter        (iter),
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
        .fix         (fix),
`endif
        .latch_out   (latch_out),
        .cnt_one     (cnt_one),
        .m_zero      (m_zero),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (directed plan + random vs reference model)
module tb_seq_divider;

    localparam int W = 16;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] dvs;
        logic [W-1:0] dvd;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic division, signed or unsigned by build.
    function automatic void model(input logic [W-1:0] dvs, input logic [W-1:0] dvd,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        int sn, sd;
        dz = (dvs == 0);
        if (dz) begin
            q = '1;
            r = dvd;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            sn = int'($signed(dvd));
            sd = int'($signed(dvs));
            q  = W'(sn / sd);
            r  = W'(sn % sd);
`else
            sn = int'(dvd);
            sd = int'(dvs);
            q  = W'(sn / sd);
            r  = W'(sn % sd);
`endif
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is first seen high.
    task automatic run_op(input logic [W-1:0] dvs, input logic [W-1:0] dvd,
                          input bit pulse_mid, input bit hold_chk,
                          input logic [W-1:0] hq, input logic [W-1:0] hr,
                          output int n);
        start   = 1'b1;
        data_in = dvs;
        @(negedge clk);
        start   = 1'b0;
        data_in = dvd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            data_in = W'($urandom);
            if (pulse_mid) start = (n == 5);
            if (hold_chk && !done) begin
                check("hold_quotient", quotient, hq);
                check("hold_remainder", remainder, hr);
            end
        end while (!done && n < 200);
        start = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [W-1:0] dvs, input logic [W-1:0] dvd,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int n);
        check({tag, "_latency"}, n, edz ? 1 : LAT);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_dz"}, div_by_zero, edz);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
`ifndef SEQ_DIVIDER_SIGNED_DIV_EN
        if (!edz) begin
            check({tag, "_invariant"}, 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
            check({tag, "_rem_lt_div"}, remainder < dvs, 1'b1);
        end
`endif
    endtask

    initial begin
        int n;
        logic [W-1:0] eq, er, dvs, dvd;
        logic edz;

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
        tbl[0] = '{dvs: 16'd7,    dvd: 16'hFF9C, q: 16'hFFF2, r: 16'hFFFE, dz: 1'b0};
        tbl[1] = '{dvs: 16'hFFFF, dvd: 16'h8000, q: 16'h8000, r: 16'h0000, dz: 1'b0};
        tbl[2] = '{dvs: 16'd0,    dvd: 16'hFFFB, q: 16'hFFFF, r: 16'hFFFB, dz: 1'b1};
        tbl[3] = '{dvs: 16'hFFF9, dvd: 16'd100,  q: 16'hFFF2, r: 16'h0002, dz: 1'b0};
`else
        tbl[0] = '{dvs: 16'd7,    dvd: 16'd100,  q: 16'd14,   r: 16'd2,    dz: 1'b0};
        tbl[1] = '{dvs: 16'd1,    dvd: 16'hFFFF, q: 16'hFFFF, r: 16'h0000, dz: 1'b0};
        tbl[2] = '{dvs: 16'hFFFF, dvd: 16'hFFFE, q: 16'h0000, r: 16'hFFFE, dz: 1'b0};
        tbl[3] = '{dvs: 16'd0,    dvd: 16'd5,    q: 16'hFFFF, r: 16'd5,    dz: 1'b1};
`endif

        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_dz", div_by_zero, 1'b0);
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].dvs, tbl[i].dvd, 1'b0, 1'b0, '0, '0, n);
            verify($sformatf("directed%0d", i), tbl[i].dvs, tbl[i].dvd,
                   tbl[i].q, tbl[i].r, tbl[i].dz, n);
        end

        // Results stay put while idling in DONE.
        repeat (4) @(negedge clk);
        check("idle_done_held", done, 1'b1);
        check("idle_quotient_held", quotient, tbl[3].q);
        check("idle_remainder_held", remainder, tbl[3].r);

        // Reset in the middle of 1000/3.
        start   = 1'b1;
        data_in = 16'd3;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd1000;
        repeat (7) @(negedge clk);
        check("midop_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_done", done, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dz", div_by_zero, 1'b0);
        check("midrst_quotient", quotient, '0);
        check("midrst_remainder", remainder, '0);
        @(negedge clk);
        run_op(16'd9, 16'd81, 1'b0, 1'b0, '0, '0, n);
        verify("after_rst", 16'd9, 16'd81, 16'd9, 16'd0, 1'b0, n);

        // Back-to-back with start pulsed during ITER; previous result must hold.
        run_op(16'd7, 16'd100, 1'b0, 1'b0, '0, '0, n);
        model(16'd7, 16'd100, eq, er, edz);
        verify("b2b_first", 16'd7, 16'd100, eq, er, edz, n);
        run_op(16'd6, 16'd50, 1'b1, 1'b1, eq, er, n);
        verify("b2b_second", 16'd6, 16'd50, 16'd8, 16'd2, 1'b0, n);

        // Random operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            dvs = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            dvd = W'($urandom);
            if (i == 5) dvs = '0;
            model(dvs, dvd, eq, er, edz);
            run_op(dvs, dvd, bit'($urandom_range(0, 1)), 1'b0, '0, '0, n);
            verify($sformatf("rand%0d", i), dvs, dvd, eq, er, edz, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse companion of the team's sequential Booth multiplier.
- It has the same operand-loading style: one shared data_in bus, with divisor and dividend loaded on consecutive cycles.
- It uses a start/done handshake and a controller + datapath split.
- It sits beside the multiplier in the arithmetic unit and yields quotient and remainder after WIDTH iteration cycles.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits (>=4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin operation; sampled only in IDLE or DONE
data_in  in  WIDTH  divisor in start cycle, dividend in following cycle
busy  out  1  high from LOAD_D through last ITER/FIX cycle
done  out  1  high while in DONE state (Moore)
div_by_zero  out  1  valid with done; divisor was 0
quotient  out  WIDTH  registered result, valid with done
remainder  out  WIDTH  registered result, valid with done

Behaviour:
- Reset (rst=1 at edge, any state, including mid-operation): state=IDLE; busy, done and div_by_zero=0; quotient and remainder=0; internal A, Q, M and counter cleared.
- Registers:
  - M: WIDTH bits, divisor.
  - Q: WIDTH bits, dividend, becomes quotient.
  - A: WIDTH+1 bits, partial remainder.
  - cnt: $clog2(WIDTH+1) bits.
- States: IDLE, LOAD_D, ITER, DONE (plus FIX when SIGNED_DIV_EN).
- IDLE: start=1 -> M<=data_in, go LOAD_D. Otherwise stay.
- LOAD_D: Q<=data_in, A<=0, cnt<=WIDTH.
  - If M==0: quotient<=all ones, remainder<=data_in, div_by_zero<=1, go DONE.
  - Else: go ITER.
- ITER, one bit per cycle:
  - Form S={A[WIDTH-1:0],Q} shifted left by 1.
  - Compute T=S_hi - {1'b0,M} in WIDTH+1 bits.
  - If T non-negative (MSB 0): A<=T, Q<={S_lo[WIDTH-1:1],1}.
  - Else: A<=S_hi, Q<={S_lo[WIDTH-1:1],0}.
  - cnt<=cnt-1.
  - When cnt==1 at the edge, latch quotient<=next Q, remainder<=next A[WIDTH-1:0], div_by_zero<=0, go DONE.
- DONE: done=1; outputs held.
  - start=1 -> M<=data_in, go LOAD_D (back-to-back ops allowed, done drops next cycle).
  - Otherwise stay in DONE indefinitely.
- Latency (unsigned, M!=0): start sampled at edge 0; done first high in cycle WIDTH+2 (18 for WIDTH=16).
- Latency (divide by zero): done first high in cycle 2.
- start while busy is ignored. data_in is ignored outside the start cycle and the LOAD_D cycle.
- quotient and remainder change only on entry to DONE or on reset. They are stable while done=1 and until the next result.
- Invariant on result: dividend == quotient*divisor + remainder, remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_DIV_EN.
- When defined:
  - Operands are two's complement.
  - LOAD_D/IDLE capture magnitudes and record sign bits.
  - After the last ITER the FSM goes to FIX, which adds one cycle: quotient negated if the operand signs differ, remainder takes the dividend's sign (truncation toward zero).
  - Overflow case: min_int/-1 -> quotient=min_int, remainder=0.
  - Divide by zero: quotient=all ones, remainder=dividend (original signed value).
  - Latency WIDTH+3.
- When undefined: unsigned only, no FIX state, no sign logic.

Decomposition:
- Package seq_div_pkg:
  - State encoding constants (IDLE, LOAD_D, ITER, FIX, DONE).
  - Default WIDTH.
  - Counter-width helper constant.
- Sub-module seq_div_datapath:
  - A/Q/M registers, trial subtractor, shift logic, counter, sign fix-up.
  - Control inputs: ld_m, ld_q, iter, fix, latch_out.
  - Status outputs: cnt_one, m_zero.
- seq_divider is the FSM controller and instantiates the datapath.

Test Plan:
1. WIDTH=16, divisor 7 then dividend 100 -> done in cycle 18, quotient=14, remainder=2, div_by_zero=0.
2. Divisor 1, dividend 0xFFFF -> quotient=0xFFFF, remainder=0. Divisor 0xFFFF, dividend 0xFFFE -> quotient=0, remainder=0xFFFE.
3. Divisor 0, dividend 5 -> done in cycle 2, div_by_zero=1, quotient=0xFFFF, remainder=5.
4. rst pulsed at cycle 8 of 1000/3 -> next cycle done=0, busy=0, quotient=remainder=0. Then divisor 9 / dividend 81 -> quotient=9, remainder=0.
5. Back-to-back: start asserted in the first DONE cycle with new operands 50/6 -> second result quotient=8, remainder=2. First result held until the second DONE. Start pulses during ITER are ignored.
6. With SEQ_DIVIDER_SIGNED_DIV_EN:
   - -100/7 -> quotient=0xFFF2, remainder=0xFFFE, done in cycle 19.
   - 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
